// File: rtl/am_pkg.sv
// -----------------------------------------------------------------------------
// am_pkg
// Shared constants and helpers for the transmit alignment marker inserter.
//   - sync header codes
//   - default marker spacing
//   - per-lane marker M bytes
//   - am_marker(): builds one lane's marker block around a BIP value
//   - bip_blk():   parity contribution of one 66-bit block to a lane BIP
// -----------------------------------------------------------------------------
package am_pkg;

    typedef logic [7:0] bip_t;

    localparam int AM_HEAD_W   = 2;
    localparam int AM_DATA_W   = 64;
    localparam int AM_BLOCK_W  = AM_HEAD_W + AM_DATA_W;
    localparam int AM_GAP_N_DEF = 16383;
    localparam int AM_LANES    = 4;

    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam logic [1:0] SYNC_DATA = 2'b01;

    // M bytes per lane, written in transmit order M0 M1 M2 M4 M5 M6 (M0 in the top byte).
    localparam logic [47:0] AM_M [0:AM_LANES-1] = '{
        48'h907647_6F89B8,
        48'hF0C4E6_0F3B19,
        48'hC5659B_3A9A64,
        48'hA2793D_5D86C2
    };

    // Marker block: octets M0,M1,M2,BIP3,M4,M5,M6,BIP7 above a control header.
    function automatic logic [AM_BLOCK_W-1:0] am_marker(input logic [47:0] m, input bip_t bip);
        bip_t bip7;
        bip7 = ~bip;
        return {bip7, m[7:0], m[15:8], m[23:16], bip, m[31:24], m[39:32], m[47:40], SYNC_CTRL};
    endfunction

    // Bits 0..6: column parity of the 8 payload octets; bit 7 also folds in header bit0^bit1.
    function automatic bip_t bip_blk(input logic [AM_BLOCK_W-1:0] blk);
        bip_t p;
        p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            p = p ^ blk[AM_HEAD_W + 8*n +: 8];
        end
        p[7] = p[7] ^ blk[0] ^ blk[1];
        return p;
    endfunction

endpackage

// File: rtl/am_bip_acc.sv
// -----------------------------------------------------------------------------
// am_bip_acc
// One lane's running BIP accumulator.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (clears to 0)
//   i_load      : replace the accumulator with i_bip (marker slot)
//   i_xor       : fold i_bip into the accumulator (accepted data block)
//   i_bip       : parity contribution of the block emitted this cycle
//   o_acc       : current accumulator value
// -----------------------------------------------------------------------------
module am_bip_acc
    import am_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_xor,
    input  bip_t i_bip,
    output bip_t o_acc
);

    bip_t r_acc;

    // Accumulator register: load wins over xor, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= 8'h00;
        end else if (i_load) begin
            r_acc <= i_bip;
        end else if (i_xor) begin
            r_acc <= r_acc ^ i_bip;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/am_tx.sv
// -----------------------------------------------------------------------------
// am_tx
// Transmit alignment marker inserter. Every GAP_N+1 emitted blocks it sends
// one marker per lane (carrying the lane's running BIP3/BIP7) followed by
// GAP_N upstream blocks. Upstream is stalled with ready_o during marker slots.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   valid_i     : block_i holds one valid block per lane
//   block_i     : LANE_N blocks, lane l at [l*BLOCK_W +: BLOCK_W]
//   ready_o     : low in the marker slot; accept = valid_i && ready_o
//   valid_o     : block_o valid this cycle (registered)
//   block_o     : emitted blocks, same layout as block_i (registered)
//   marker_v_o  : block_o is an alignment marker on every lane (registered)
// -----------------------------------------------------------------------------
module am_tx
    import am_pkg::*;
#(
    parameter int LANE_N  = 4,
    parameter int HEAD_W  = 2,
    parameter int DATA_W  = 64,
    parameter int BLOCK_W = HEAD_W + DATA_W,
    parameter int GAP_N   = AM_GAP_N_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_i,
    input  logic [LANE_N*BLOCK_W-1:0] block_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [LANE_N*BLOCK_W-1:0] block_o,
    output logic                      marker_v_o
);

    localparam int CNT_W = $clog2(GAP_N + 1);

    logic [CNT_W-1:0]          r_cnt;
    logic                      r_valid;
    logic                      r_marker;
    logic [LANE_N*BLOCK_W-1:0] r_block;

    logic                      w_mark_slot;
    logic                      w_take;
    logic [LANE_N*BLOCK_W-1:0] w_marker_all;

    assign w_mark_slot = (r_cnt == '0);
    // A data block is consumed only in a data slot; in the marker slot it stays upstream.
    assign w_take      = (!w_mark_slot) && valid_i;

    for (genvar g = 0; g < LANE_N; g++) begin : g_lane
        logic [BLOCK_W-1:0] w_marker;
        bip_t               w_acc;
        bip_t               w_bip;

        assign w_marker = am_marker(AM_M[g % AM_LANES], w_acc);
        // In the marker slot the accumulator restarts from the marker's own parity.
        assign w_bip    = w_mark_slot ? bip_blk(w_marker)
                                      : bip_blk(block_i[g*BLOCK_W +: BLOCK_W]);
        assign w_marker_all[g*BLOCK_W +: BLOCK_W] = w_marker;

        am_bip_acc u_acc (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_mark_slot),
            .i_xor  (w_take),
            .i_bip  (w_bip),
            .o_acc  (w_acc)
        );
    end

    // Slot counter: marker slot -> 1; accepted data advances with wrap GAP_N -> 0; idle holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_mark_slot) begin
            r_cnt <= CNT_W'(1);
        end else if (w_take) begin
            if (r_cnt == CNT_W'(GAP_N)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Output register: marker, pass-through, or idle with block_o held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_marker <= 1'b0;
            r_block  <= '0;
        end else if (w_mark_slot) begin
            r_valid  <= 1'b1;
            r_marker <= 1'b1;
            r_block  <= w_marker_all;
        end else if (w_take) begin
            r_valid  <= 1'b1;
            r_marker <= 1'b0;
            r_block  <= block_i;
        end else begin
            r_valid  <= 1'b0;
            r_marker <= 1'b0;
            r_block  <= r_block;
        end
    end

    assign ready_o    = !w_mark_slot;
    assign valid_o    = r_valid;
    assign marker_v_o = r_marker;
    assign block_o    = r_block;

endmodule
